// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Wishbone B4 classic master between the
// instruction-fetch port and the MEM-stage data port. MEM has fixed priority,
// one transaction is outstanding at a time, and results are held in per-port
// done flags until the pipeline advances. A flush drains the in-flight cycle
// and throws its data away. A watchdog ends cycles that are never acked.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        stallreq_if_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stallreq_mem_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Last watchdog value before a hung cycle is forced to end.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [15:0] wdog_q, wdog_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic        wb_we_q, wb_we_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        bus_err_q, bus_err_d;

  logic if_elig;
  logic mem_elig;

  assign if_elig  = if_req_i & ~if_done_q;
  assign mem_elig = mem_req_i & ~mem_done_q;

  // Next-state logic: grant, bus completion, drain, watchdog and done flags.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    wdog_d      = wdog_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_d    = wb_dat_q;
    wb_we_d     = wb_we_q;
    wb_sel_d    = wb_sel_q;
    wb_cyc_d    = wb_cyc_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    bus_err_d   = 1'b0;

    // Pipeline advancing releases held results; a completion below may re-set.
    if (stall_i == 6'b0) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end else begin
      if_done_d  = if_done_q;
      mem_done_d = mem_done_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (mem_elig) begin
          owner_d  = OWNER_MEM;
          wb_adr_d = mem_addr_i;
          wb_dat_d = mem_wdata_i;
          wb_we_d  = mem_we_i;
          wb_sel_d = mem_sel_i;
          wb_cyc_d = 1'b1;
          wdog_d   = 16'd0;
          state_d  = ST_BUS;
        end else if (if_elig) begin
          owner_d  = OWNER_IF;
          wb_adr_d = if_addr_i;
          wb_dat_d = 32'd0;
          wb_we_d  = 1'b0;
          wb_sel_d = 4'hF;
          wb_cyc_d = 1'b1;
          wdog_d   = 16'd0;
          state_d  = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUS: begin
        if (wb_ack_i) begin
          wb_cyc_d = 1'b0;
          state_d  = ST_IDLE;
          // An ack coinciding with a flush is discarded like a drained cycle.
          if (!flush_i) begin
            if (owner_q == OWNER_MEM) begin
              mem_done_d = 1'b1;
              if (!wb_we_q) begin
                mem_rdata_d = wb_dat_i;
              end else begin
                mem_rdata_d = mem_rdata_q;
              end
            end else begin
              if_done_d  = 1'b1;
              if_rdata_d = wb_dat_i;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wdog_q == WDOG_LAST) begin
          wb_cyc_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
          if (!flush_i) begin
            if (owner_q == OWNER_MEM) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = 32'd0;
            end else begin
              if_done_d  = 1'b1;
              if_rdata_d = 32'd0;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (flush_i) begin
          wdog_d  = wdog_q + 16'd1;
          state_d = ST_DRAIN;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      ST_DRAIN: begin
        if (wb_ack_i) begin
          wb_cyc_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          wb_cyc_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      default: begin
        wb_cyc_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // A flush wins over every set or hold of the done flags.
    if (flush_i) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end else begin
      if_done_d  = if_done_d;
      mem_done_d = mem_done_d;
    end
  end

  // State and output registers with synchronous reset abandoning any cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_IF;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      wdog_q      <= 16'd0;
      wb_adr_q    <= 32'd0;
      wb_dat_q    <= 32'd0;
      wb_we_q     <= 1'b0;
      wb_sel_q    <= 4'd0;
      wb_cyc_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      wdog_q      <= wdog_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      wb_we_q     <= wb_we_d;
      wb_sel_q    <= wb_sel_d;
      wb_cyc_q    <= wb_cyc_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign wb_adr_o       = wb_adr_q;
  assign wb_dat_o       = wb_dat_q;
  assign wb_we_o        = wb_we_q;
  assign wb_sel_o       = wb_sel_q;
  assign wb_cyc_o       = wb_cyc_q;
  assign wb_stb_o       = wb_cyc_q;
  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign bus_err_o      = bus_err_q;
  assign stallreq_if_o  = if_req_i & ~if_done_q;
  assign stallreq_mem_o = mem_req_i & ~mem_done_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the instruction-fetch port and the MEM-stage data port of the OpenMIPS pipeline onto a single shared Wishbone B4 classic master bus. Only one transaction is outstanding at a time. The block raises per-port stall requests toward `ctrl` until each port's data is ready, and holds completed results until the pipeline advances. On an exception `flush` it drains an in-flight cycle and discards the result. A watchdog terminates hung bus cycles.

## Interface
- `TIMEOUT`, default 255: number of cycles `wb_cyc_o` may stay high without `wb_ack_i` before the cycle is forced to end. Legal range is 1–65535.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `stall_i`  in  6  pipeline stall vector from `ctrl` (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, bit 5 spare)
- `flush_i`  in  1  exception flush from `ctrl`
- `if_req_i`  in  1  fetch request; held high while a fetch is wanted
- `if_addr_i`  in  32  fetch address
- `if_rdata_o`  out  32  fetched instruction (registered)
- `stallreq_if_o`  out  1  equals `if_req_i & ~if_done`
- `mem_req_i`  in  1  data access request
- `mem_we_i`  in  1  1 = write
- `mem_sel_i`  in  4  byte enables
- `mem_addr_i`  in  32  data address
- `mem_wdata_i`  in  32  write data
- `mem_rdata_o`  out  32  read data (registered)
- `stallreq_mem_o`  out  1  equals `mem_req_i & ~mem_done`
- `wb_adr_o`  out  32, `wb_dat_o`  out  32, `wb_we_o`  out  1, `wb_sel_o`  out  4, `wb_stb_o`  out  1, `wb_cyc_o`  out  1: registered Wishbone master outputs
- `wb_dat_i`  in  32, `wb_ack_i`  in  1: Wishbone slave response
- `bus_err_o`  out  1  one-cycle pulse when the watchdog expires

## Operation
- Internal state:
  - FSM: IDLE, BUS, DRAIN.
  - `owner` (IF or MEM).
  - Per-port done flags `if_done` and `mem_done`.
  - 16-bit watchdog counter `wdog`.
- IDLE:
  - A port is *eligible* when `req & ~done`.
  - If MEM is eligible, grant MEM; otherwise, if IF is eligible, grant IF. MEM has fixed priority.
  - On grant: latch the requester's addr/we/sel/wdata onto `wb_*`, set `cyc`/`stb`, clear `wdog`, go to BUS.
  - IF grants drive `we=0` and `sel=4'hF`.
  - No grant is made while `flush_i` is 1.
- BUS:
  - On `wb_ack_i`: drop `cyc`/`stb` and set `owner`'s done flag.
  - For a read, capture `wb_dat_i` into `owner`'s rdata register. A MEM write leaves `mem_rdata_o` unchanged.
  - Go to IDLE.
  - If `flush_i` is 1 and there is no ack, go to DRAIN and keep `cyc`/`stb` high.
  - If `wdog == TIMEOUT-1` and there is no ack:
    - drop `cyc`/`stb`;
    - pulse `bus_err_o`;
    - set the done flag;
    - load 0 into the owner's rdata;
    - go to IDLE.
  - Otherwise increment `wdog`.
- DRAIN:
  - Wait for `wb_ack_i` or watchdog expiry.
  - Then drop `cyc`/`stb`, discard the data, leave the done flags clear, and go to IDLE.
  - `bus_err_o` pulses only on expiry.
- Done flags:
  - Cleared on any edge where `stall_i == 6'b0` (the pipeline advances) or `flush_i == 1`.
  - A set from an ack in BUS takes precedence over a `stall_i` clear in the same edge.
  - `flush_i` overrides everything, and an ack arriving in the same edge as `flush_i` is treated as DRAIN (data discarded).
- When both ports have requests pending, one port's done flag does not block granting the other. Example: IF done and waiting while MEM is serviced. This avoids deadlock.
- `rst` takes priority over all other inputs. It forces IDLE immediately, including mid-cycle, and the bus cycle is abandoned.

## Timing
- Reset values: all `wb_*` outputs 0, `if_rdata_o`/`mem_rdata_o` = 0, `bus_err_o` = 0, done flags 0, `wdog` = 0. The stallreq outputs follow their combinational equations.
- Request seen in IDLE at edge N → `cyc`/`stb` high after edge N.
- Zero-wait ack, sampled at edge N+1 → `cyc` low, done set and rdata valid after edge N+1. Minimum transaction is 2 cycles.
- A slave with k wait states adds k cycles.
- `stallreq_*` is combinational: it falls in the same cycle the done flag rises.
- IDLE lasts at least 1 cycle between transactions. Back-to-back grants occur at every other edge at best.
- Watchdog: `cyc` is high for exactly `TIMEOUT` cycles before the forced drop.

## Test plan
- **Single fetch:** `if_req=1`, `addr=0x100`, slave acks after 0 wait states with `0x3C010001` → `cyc` high for 1 cycle; `if_rdata_o=0x3C010001`; `stallreq_if` low from cycle 3; with `stall_i=0`, `if_done` clears at the next edge.
- **Simultaneous requests:** `if_req` and `mem_req` (read, `0x200`) in the same cycle → MEM served first, then IF. `wb_adr_o` sequence is `0x200`, then `0x100`. `stallreq_if` stays high throughout the MEM transaction.
- **Write:** `mem_we=1`, `sel=4'b0011`, `wdata=0xDEADBEEF`, `addr=0x40` → the `wb_*` outputs carry exactly these values; `mem_rdata_o` is unchanged; slave with 3 wait states → `cyc` high for 4 cycles.
- **Flush mid-cycle:** flush one cycle after grant, ack 2 cycles later with `0x12345678` → DRAIN; the rdata register is not updated; done flags stay 0; no grant until IDLE.
- **Timeout:** `TIMEOUT=4`, slave never acks → `cyc` high for 4 cycles; `bus_err_o` pulses once; owner rdata = 0; stallreq drops.
- **Reset mid-BUS:** `rst` asserted while `cyc=1` → all outputs at reset values after the next edge; a late ack is ignored.
